fetch_unit: RTL and testbench

- Instruction fetch stage. Consumes the redirect/bubble outputs of the pipeline control block (next_pc_en, next_pc, bubble_fetch) and drives the instruction-memory request port.
- Presents fetched words to decode over a valid/ready handshake.
- Tracks in-flight requests and buffers early responses. Discards stale responses after a jump or trap redirect, so decode never sees a wrong-path instruction.

---
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues word fetches to instruction memory, tracks requests in flight,
// buffers responses in a small FIFO and presents them to decode over a
// valid/ready handshake. Responses belonging to requests issued before a
// redirect are counted out and dropped.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect raises a
// fetch fault instead of silently aligning the target).
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_pc_en,
    input  logic [31:0] next_pc,
    input  logic        bubble_fetch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        dec_ready
);

    localparam int unsigned   PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned   CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0]   MAX_OCC   = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] FIRST_IDX = '0;
    localparam logic [PW-1:0] LAST_IDX  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]   NOP_INST  = 32'h0000_0013;

    // Circular index advance; depth need not be a power of two.
    function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? FIRST_IDX : idx + PW'(1);
    endfunction

    // Architectural state
    logic          r_active;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;
    logic [PW-1:0] r_buf_wr;
    logic [PW-1:0] r_buf_rd;
    logic [31:0]   r_inst_hold;
    logic [31:0]   r_pc_hold;

    // Storage arrays
    logic [31:0]   r_pcq      [MAX_OUTSTANDING];
    logic [31:0]   r_buf_data [MAX_OUTSTANDING];
    logic [31:0]   r_buf_pc   [MAX_OUTSTANDING];

    // Combinational control
    logic [31:0]   w_target;
    logic          w_misaligned;
    logic          w_halt;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_grant;
    logic          w_keep;
    logic          w_drop;
    logic          w_inst_valid;
    logic          w_pop;
    logic [31:0]   w_head_data;
    logic [31:0]   w_head_pc;

`ifdef FETCH_MISALIGN_EN
    assign w_target     = next_pc;
    assign w_misaligned = (next_pc[1:0] != 2'b00);
`else
    assign w_target     = next_pc & 32'hFFFF_FFFC;
    assign w_misaligned = 1'b0;
`endif

    // Responses still owed by memory count against capacity, including
    // those that will be discarded, so a kept response always has a slot.
    assign w_occupancy  = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req        = r_active & ~bubble_fetch & ~next_pc_en & ~w_halt
                        & (w_occupancy < MAX_OCC);
    assign w_grant      = w_req & imem_gnt;

    // A response arriving in a redirect cycle belongs to the old path.
    assign w_keep       = imem_rvalid & ~next_pc_en & (r_discard == '0);
    assign w_drop       = imem_rvalid & ~next_pc_en & (r_discard != '0);

    // Valid is withheld during a redirect so decode never accepts an entry
    // that is being flushed.
    assign w_inst_valid = (r_count != '0) & ~bubble_fetch & ~next_pc_en;
    assign w_pop        = w_inst_valid & dec_ready;
    assign w_head_data  = r_buf_data[r_buf_rd];
    assign w_head_pc    = r_buf_pc[r_buf_rd];

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign inst_valid   = w_inst_valid;
    assign inst         = w_inst_valid ? w_head_data : r_inst_hold;
    assign inst_pc      = w_inst_valid ? w_head_pc   : r_pc_hold;

    // Fetch PC, request credits and the stale-response discard counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_pc       <= RESET_ADDR;
            r_inflight <= '0;
            r_discard  <= '0;
            r_pcq_wr   <= FIRST_IDX;
            r_pcq_rd   <= FIRST_IDX;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= r_inflight + CW'(w_grant) - CW'(imem_rvalid);
            if (next_pc_en) begin
                r_pc      <= w_target;
                r_discard <= r_inflight - CW'(imem_rvalid);
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
            if (w_grant) begin
                r_pcq_wr <= inc_idx(r_pcq_wr);
            end
            if (imem_rvalid) begin
                r_pcq_rd <= inc_idx(r_pcq_rd);
            end
        end
    end

    // Response buffer pointers and occupancy; a redirect flushes it and may
    // seed it with a single fault entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_wr <= FIRST_IDX;
            r_buf_rd <= FIRST_IDX;
            r_count  <= '0;
        end else if (next_pc_en) begin
            r_buf_rd <= FIRST_IDX;
            r_buf_wr <= w_misaligned ? inc_idx(FIRST_IDX) : FIRST_IDX;
            r_count  <= CW'(w_misaligned);
        end else begin
            if (w_keep) begin
                r_buf_wr <= inc_idx(r_buf_wr);
            end
            if (w_pop) begin
                r_buf_rd <= inc_idx(r_buf_rd);
            end
            r_count <= r_count + CW'(w_keep) - CW'(w_pop);
        end
    end

    // Last presented instruction, held while the output is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_hold <= '0;
            r_pc_hold   <= '0;
        end else if (w_inst_valid) begin
            r_inst_hold <= w_head_data;
            r_pc_hold   <= w_head_pc;
        end
    end

    // Request-address queue and response buffer payload.
    // NOTE: storage arrays carry no reset; pointers and counts alone define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
        if (next_pc_en && w_misaligned) begin
            r_buf_data[FIRST_IDX] <= NOP_INST;
            r_buf_pc[FIRST_IDX]   <= next_pc;
        end else if (w_keep) begin
            r_buf_data[r_buf_wr] <= imem_rdata;
            r_buf_pc[r_buf_wr]   <= r_pcq[r_pcq_rd];
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic r_halt;
    logic r_buf_fault [MAX_OUTSTANDING];

    // A misaligned redirect parks fetch until the next redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt <= 1'b0;
        end else if (next_pc_en) begin
            r_halt <= w_misaligned;
        end
    end

    // Fault tag travels alongside each buffer entry.
    always_ff @(posedge clk) begin
        if (next_pc_en && w_misaligned) begin
            r_buf_fault[FIRST_IDX] <= 1'b1;
        end else if (w_keep) begin
            r_buf_fault[r_buf_wr] <= 1'b0;
        end
    end

    assign w_halt     = r_halt;
    assign inst_fault = w_inst_valid & r_buf_fault[r_buf_rd];
`else
    assign w_halt     = 1'b0;
    assign inst_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with an in-order memory responder,
// a queue-based reference model and directed scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          MAX        = 2;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        next_pc_en   = 1'b0;
    logic [31:0] next_pc      = '0;
    logic        bubble_fetch = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt     = 1'b1;
    logic        imem_rvalid  = 1'b0;
    logic [31:0] imem_rdata   = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        dec_ready    = 1'b0;

    fetch_unit #(
        .RESET_ADDR      (RESET_ADDR),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_pc_en   (next_pc_en),
        .next_pc      (next_pc),
        .bubble_fetch (bubble_fetch),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_fault   (inst_fault),
        .dec_ready    (dec_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory responder: in-order, fixed latency from grant.
    typedef struct { logic [31:0] addr; int due; } mrsp_t;
    mrsp_t mem_q[$];
    int    lat = 1;
    int    cyc = 0;

    always @(posedge clk) begin
        #1;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // Reference model: outstanding requests carry a stale flag; the buffer
    // is a plain queue of {data, pc, fault}.
    typedef struct { logic [31:0] pc; logic stale; } pend_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; logic fault; } ent_t;
    pend_t       m_pend[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_active;
    logic [31:0] m_hold_inst;
    logic [31:0] m_hold_pc;
    logic        model_on = 1'b0;

    // Observation log used by the directed checks.
    int          gnt_total;
    int          first_gnt;
    int          first_valid;
    logic [31:0] gnt_addr[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_inst[$];
    logic        deliv_fault[$];

    task automatic model_reset();
        m_pend.delete();
        m_buf.delete();
        m_pc        = RESET_ADDR;
        m_halt      = 1'b0;
        m_active    = 1'b0;
        m_hold_inst = '0;
        m_hold_pc   = '0;
        gnt_total   = 0;
        first_gnt   = -1;
        first_valid = -1;
        gnt_addr.delete();
        deliv_pc.delete();
        deliv_inst.delete();
        deliv_fault.delete();
    endtask

    logic        e_req, e_valid, e_fault, misal;
    logic [31:0] e_inst, e_pc;
    pend_t       p;

    // Compare the DUT against the model every cycle, then advance both the
    // model and the memory responder by one clock.
    always @(negedge clk) begin
        if (model_on) begin
            e_req   = m_active && !bubble_fetch && !next_pc_en && !m_halt
                      && (m_pend.size() + m_buf.size() < MAX);
            e_valid = (m_buf.size() != 0) && !bubble_fetch && !next_pc_en;
            if (e_valid) begin
                e_inst  = m_buf[0].data;
                e_pc    = m_buf[0].pc;
                e_fault = m_buf[0].fault;
            end else begin
                e_inst  = m_hold_inst;
                e_pc    = m_hold_pc;
                e_fault = 1'b0;
            end
            check1("imem_req", imem_req, e_req);
            check("imem_addr", imem_addr, m_pc);
            check1("inst_valid", inst_valid, e_valid);
            check("inst", inst, e_inst);
            check("inst_pc", inst_pc, e_pc);
            check1("inst_fault", inst_fault, e_fault);

            if (inst_valid && first_valid < 0) first_valid = cyc;
            if (inst_valid && dec_ready) begin
                deliv_pc.push_back(inst_pc);
                deliv_inst.push_back(inst);
                deliv_fault.push_back(inst_fault);
            end

            if (imem_rvalid) begin
                if (mem_q.size() != 0) void'(mem_q.pop_front());
                check1("rvalid_has_credit", m_pend.size() != 0, 1'b1);
            end
            if (imem_req && imem_gnt) begin
                gnt_total++;
                if (first_gnt < 0) first_gnt = cyc;
                gnt_addr.push_back(imem_addr);
                mem_q.push_back('{imem_addr, cyc + lat});
            end

            if (e_valid) begin
                m_hold_inst = m_buf[0].data;
                m_hold_pc   = m_buf[0].pc;
                if (dec_ready) void'(m_buf.pop_front());
            end
            if (imem_rvalid && m_pend.size() != 0) begin
                p = m_pend.pop_front();
                if (!p.stale && !next_pc_en) m_buf.push_back('{mem_word(p.pc), p.pc, 1'b0});
            end
            if (next_pc_en) begin
                foreach (m_pend[i]) m_pend[i].stale = 1'b1;
                m_buf.delete();
`ifdef FETCH_MISALIGN_EN
                misal = (next_pc[1:0] != 2'b00);
                m_pc  = next_pc;
`else
                misal = 1'b0;
                m_pc  = {next_pc[31:2], 2'b00};
`endif
                m_halt = misal;
                if (misal) m_buf.push_back('{32'h0000_0013, next_pc, 1'b1});
            end else if (e_req && imem_gnt) begin
                m_pend.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            m_active = 1'b1;
            check1("buffer_bound", m_buf.size() <= MAX, 1'b1);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic look();
        #3;
    endtask

    task automatic do_reset();
        model_on     = 1'b0;
        mem_q.delete();
        rst_n        = 1'b0;
        next_pc_en   = 1'b0;
        bubble_fetch = 1'b0;
        dec_ready    = 1'b0;
        imem_gnt     = 1'b1;
        steps(2);
        model_reset();
        rst_n    = 1'b1;
        model_on = 1'b1;
    endtask

    task automatic wait_gnts(input int n);
        for (int k = 0; k < 40 && gnt_total < n; k++) step();
        check1("wait_grants", gnt_total >= n, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] target);
        next_pc_en = 1'b1;
        next_pc    = target;
        step();
        next_pc_en = 1'b0;
    endtask

    function automatic int count_pc(input logic [31:0] pc);
        int c = 0;
        foreach (deliv_pc[i]) if (deliv_pc[i] == pc) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        // Values while reset is held.
        model_reset();
        #12;
        check1("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_ADDR);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check1("rst_inst_fault", inst_fault, 1'b0);

        // Streaming with grant always and one-cycle memory latency.
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        steps(14);
        check1("t1_gnt_count", gnt_addr.size() >= 4, 1'b1);
        check("t1_addr0", gnt_addr[0], 32'h0);
        check("t1_addr1", gnt_addr[1], 32'h4);
        check("t1_addr2", gnt_addr[2], 32'h8);
        check("t1_addr3", gnt_addr[3], 32'hC);
        check("t1_latency", 32'(first_valid - first_gnt), 32'd2);
        check1("t1_deliv_count", deliv_pc.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) check("t1_deliv_pc", deliv_pc[i], 32'(4 * i));
        check("t1_inst0", deliv_inst[0], 32'hC0DE_0000);

        // Decode stalled: capacity fills to MAX then requests stop.
        do_reset();
        dec_ready = 1'b0;
        steps(6);
        look();
        check("t2_outstanding", 32'(gnt_total), 32'd2);
        check1("t2_req_blocked", imem_req, 1'b0);
        dec_ready = 1'b1;
        steps(8);
        check1("t2_deliv_count", deliv_pc.size() >= 3, 1'b1);
        check("t2_pc0", deliv_pc[0], 32'h0);
        check("t2_pc1", deliv_pc[1], 32'h4);
        check("t2_pc2", deliv_pc[2], 32'h8);

        // Redirect with 0x8 and 0xC in flight.
        do_reset();
        lat       = 4;
        dec_ready = 1'b1;
        wait_gnts(4);
        redirect(32'h100);
        steps(14);
        check1("t3_deliv_count", deliv_pc.size() >= 3, 1'b1);
        check("t3_pc0", deliv_pc[0], 32'h0);
        check("t3_pc1", deliv_pc[1], 32'h4);
        check("t3_pc2", deliv_pc[2], 32'h100);
        check("t3_inst2", deliv_inst[2], 32'hC0DE_0100);
        check("t3_no_stale", 32'(count_pc(32'h8) + count_pc(32'hC)), 32'd0);

        // Fetch bubble holding a buffered entry at 0x20.
        do_reset();
        lat       = 1;
        dec_ready = 1'b0;
        step();
        redirect(32'h20);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            look();
            if (inst_valid) found = 1;
        end
        check("t4_found", 32'(found), 32'd1);
        check("t4_head_pc", inst_pc, 32'h20);
        for (int k = 0; k < 3; k++) begin
            step();
            bubble_fetch = 1'b1;
            dec_ready    = 1'b1;
            look();
            check1("t4_bubble_valid", inst_valid, 1'b0);
            check1("t4_bubble_req", imem_req, 1'b0);
        end
        step();
        bubble_fetch = 1'b0;
        look();
        check1("t4_release_valid", inst_valid, 1'b1);
        check("t4_release_pc", inst_pc, 32'h20);
        check("t4_release_inst", inst, 32'hC0DE_0020);
        steps(6);

        // Back-to-back redirects with a response landing in the first one.
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        wait_gnts(1);
        next_pc_en = 1'b1;
        next_pc    = 32'h200;
        step();
        next_pc    = 32'h300;
        step();
        next_pc_en = 1'b0;
        steps(10);
        check1("t5_deliv_count", deliv_pc.size() >= 2, 1'b1);
        check("t5_pc0", deliv_pc[0], 32'h300);
        check("t5_inst0", deliv_inst[0], 32'hC0DE_0300);
        check("t5_pc1", deliv_pc[1], 32'h304);
        check("t5_no_wrong_path", 32'(count_pc(32'h200) + count_pc(32'h0)), 32'd0);

        // Misaligned redirect target.
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        step();
        redirect(32'h102);
        steps(6);
`ifdef FETCH_MISALIGN_EN
        look();
        check("t6_single_entry", 32'(deliv_pc.size()), 32'd1);
        check("t6_fault_pc", deliv_pc[0], 32'h102);
        check("t6_fault_inst", deliv_inst[0], 32'h0000_0013);
        check1("t6_fault_tag", deliv_fault[0], 1'b1);
        check("t6_no_grants", 32'(gnt_total), 32'd0);
        check1("t6_halted", imem_req, 1'b0);
        step();
        redirect(32'h104);
        steps(6);
        check1("t6_resume_count", deliv_pc.size() >= 2, 1'b1);
        check("t6_resume_pc", deliv_pc[1], 32'h104);
        check("t6_resume_inst", deliv_inst[1], 32'hC0DE_0104);
        check1("t6_resume_fault", deliv_fault[1], 1'b0);
`else
        check1("t6_deliv_count", deliv_pc.size() >= 1, 1'b1);
        check("t6_aligned_pc", deliv_pc[0], 32'h100);
        check("t6_aligned_inst", deliv_inst[0], 32'hC0DE_0100);
        check1("t6_no_fault", deliv_fault[0], 1'b0);
        check("t6_first_addr", gnt_addr[0], 32'h100);
`endif

        // Irregular grants, decode stalls and bubbles.
        do_reset();
        lat = 2;
        for (int i = 0; i < 30; i++) begin
            imem_gnt     = (i % 3 != 1);
            dec_ready    = (i % 4 != 3);
            bubble_fetch = (i == 10 || i == 11);
            step();
        end
        imem_gnt     = 1'b1;
        dec_ready    = 1'b1;
        bubble_fetch = 1'b0;
        steps(10);
        check1("t7_deliv_count", deliv_pc.size() >= 5, 1'b1);
        for (int i = 0; i < 5; i++) check("t7_deliv_pc", deliv_pc[i], 32'(4 * i));

        model_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
